imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Memory-side end of the instruction-fetch refill interface: answers the instruction cache's miss request (ram_address plus miss flag) with a burst of memory words, each qualified by a one-cycle word_ready pulse.
- Sits between the fetch unit's cache controller and the instruction storage.
- Models configurable access latency so the fetch stall path is exercised realistically.
- Provides a program-load write port for boot and testbench preload.

Parameters:
- ADDR_W, 32, byte address width; matches pc_size.
- WORD_W, 32, returned word width; matches memory_word.
- LINE_WORDS, 4, words per refill burst; power of two, ≥1.
- DEPTH_LOG, 12, log2 of storage depth in words.
- FIRST_LAT, 3, cycles from request capture to first word_ready; ≥1.
- BEAT_GAP, 0, idle cycles between consecutive beats.

Ports:
- clk  in  1  clock; single clock domain.
- nrst  in  1  reset, asynchronous assert, active-low.
- req  in  1  refill request; driven by the cache miss flag.
- ram_address  in  ADDR_W  byte address of the missing instruction.
- mem_word  out  WORD_W  returned word; valid only while word_ready=1.
- word_ready  out  1  one-cycle strobe per delivered word.
- busy  out  1  high from request capture until return to IDLE.
- prog_we  in  1  storage write enable.
- prog_addr  in  DEPTH_LOG  word index to write.
- prog_data  in  WORD_W  word to write.

Behaviour:
- Reset values:
  - Asynchronous on nrst low: state=IDLE, mem_word=0, word_ready=0, busy=0, all counters 0.
  - Storage contents are not reset.
- State machine imem_state_t, with states IDLE, LAT, BEAT, GAP, HOLD:
  - IDLE: if req=1, latch base = ram_address with the low log2(LINE_WORDS)+2 bits cleared, set beat=0, load lat_cnt=FIRST_LAT-1, set busy=1, and go to LAT.
  - LAT: decrement lat_cnt. When lat_cnt reaches 0, go to BEAT.
  - BEAT: issue the storage read for word index (base>>2)+beat, truncated to DEPTH_LOG bits. Data is registered, so word_ready=1 and mem_word appear the cycle after BEAT is entered.
    - If beat==LINE_WORDS-1, go to HOLD.
    - Otherwise increment beat and go to GAP, or stay in BEAT when BEAT_GAP=0.
  - GAP: count BEAT_GAP cycles, then go to BEAT.
  - HOLD: the final word_ready is visible this cycle. Wait until req=0, then go to IDLE with busy=0. This guarantees the same miss is never served twice.
- Latency: the first word_ready occurs exactly FIRST_LAT+1 cycles after the capture edge.
  - With BEAT_GAP=0, beats are back-to-back.
  - A full line is delivered in LINE_WORDS consecutive cycles.
- Beat order: always ascending from the line-aligned base. There is no critical-word-first ordering.
- Address wrap: word index is modulo 2^DEPTH_LOG. Out-of-range addresses alias and are not flagged.
- Request drop mid-transfer (in LAT, BEAT or GAP): return to IDLE next cycle. No further word_ready pulses are issued and busy drops. A word already registered on that edge is still strobed once.
- req held high in IDLE after HOLD: no re-capture until req has been observed low for at least one cycle.
- ram_address changes while busy: ignored; the base is latched at capture only.
- Simultaneous prog_we and a burst read to the same index: the read returns the old data, the write commits.
- prog_we is accepted in every state.
- word_ready is never high for two cycles when BEAT_GAP>0.
- mem_word holds its last value when word_ready=0.

Decomposition:
- Add to the shared constants package:
  - imem_state_t enum.
  - Defaults for line size and latency (imem_line_words, imem_first_lat).
  - Reuse the existing memory_word and pc_size macros for widths.
- One sub-module, imem_array: 2^DEPTH_LOG×WORD_W storage with one registered read port and one write port (read-old-data on collision).
- The FSM and counters stay in imem_responder.

Test Plan:
1. Defaults; preload words 0..7 with 0x1000_0000+i; req=1, ram_address=0x0000_0014 → base 0x10, word_ready on cycles 4,5,6,7 after capture with mem_word 0x1000_0004..0x1000_0007; busy falls the cycle after req drops.
2. BEAT_GAP=2, LINE_WORDS=2, ram_address=0x0 → two word_ready pulses 3 cycles apart carrying words 0 and 1; word_ready is never high on consecutive cycles.
3. req deasserted 1 cycle after the first beat → at most one further word_ready, then state IDLE, busy=0; a new req at 0x20 is then served from word 8.
4. req held high for 10 cycles after HOLD → exactly LINE_WORDS pulses in total; no second burst until req toggles low→high.
5. nrst pulsed low asynchronously mid-BEAT → word_ready, busy and mem_word go to 0 immediately without a clock edge; after release, a fresh request behaves as in scenario 1.
6. DEPTH_LOG=4, ram_address=0x0000_0040 → aliases to word 0 and returns the preloaded word 0; a prog_we write of 0xDEAD_BEEF to index 1 on the same cycle word 1 is read → burst shows the old value, and a subsequent burst shows 0xDEAD_BEEF.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared constants and types for the instruction-memory refill responder.
package imem_responder_pkg;

  // Width defaults shared with the fetch unit
  localparam int unsigned pc_size     = 32;
  localparam int unsigned memory_word = 32;

  // Refill burst defaults
  localparam int unsigned imem_line_words = 4;
  localparam int unsigned imem_first_lat  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LAT,
    BEAT,
    GAP,
    HOLD
  } imem_state_t;

  // Bits needed to hold a counter value in 0..maxv (at least one bit)
  function automatic int unsigned imem_cnt_w(input int unsigned maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction storage: one registered read port, one write
// port. A read and write to the same index on one edge returns the old word.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 12,
  parameter int unsigned WORD_W    = memory_word
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_re,
  input  logic [DEPTH_LOG-1:0] i_raddr,
  output logic [WORD_W-1:0]    o_rdata,
  input  logic                 i_we,
  input  logic [DEPTH_LOG-1:0] i_waddr,
  input  logic [WORD_W-1:0]    i_wdata
);

  logic [WORD_W-1:0] r_mem [2**DEPTH_LOG];
  logic [WORD_W-1:0] r_rdata;

  // Storage write; contents are never reset
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for instruction-cache refills: captures a miss,
// waits FIRST_LAT cycles, then streams LINE_WORDS ascending words from the
// line-aligned base, one word_ready strobe per word.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = pc_size,
  parameter int unsigned WORD_W     = memory_word,
  parameter int unsigned LINE_WORDS = imem_line_words,
  parameter int unsigned DEPTH_LOG  = 12,
  parameter int unsigned FIRST_LAT  = imem_first_lat,
  parameter int unsigned BEAT_GAP   = 0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 req,
  input  logic [ADDR_W-1:0]    ram_address,
  output logic [WORD_W-1:0]    mem_word,
  output logic                 word_ready,
  output logic                 busy,
  input  logic                 prog_we,
  input  logic [DEPTH_LOG-1:0] prog_addr,
  input  logic [WORD_W-1:0]    prog_data
);

  localparam int unsigned LINE_LOG = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 0;
  localparam int unsigned BEAT_W   = imem_cnt_w(LINE_WORDS - 1);
  localparam int unsigned LAT_W    = imem_cnt_w(FIRST_LAT - 1);
  localparam int unsigned GAP_W    = imem_cnt_w(BEAT_GAP);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(FIRST_LAT - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = (BEAT_GAP > 0) ? GAP_W'(BEAT_GAP - 1) : '0;

  imem_state_t          r_state;
  logic [DEPTH_LOG-1:0] r_base_idx;
  logic [BEAT_W-1:0]    r_beat;
  logic [LAT_W-1:0]     r_lat_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_busy;
  logic                 r_word_ready;

  logic [DEPTH_LOG-1:0] w_raw_idx;
  logic [DEPTH_LOG-1:0] w_cap_idx;
  logic [DEPTH_LOG-1:0] w_rd_idx;
  logic                 w_rd_en;
  logic [WORD_W-1:0]    w_rdata;

  // Word index of the request, aligned down to the start of its line;
  // the upper address bits alias away by truncation
  assign w_raw_idx = ram_address[DEPTH_LOG+1:2];
  assign w_cap_idx = (w_raw_idx >> LINE_LOG) << LINE_LOG;

  // A read is issued on every BEAT cycle while the request is still held
  assign w_rd_en  = (r_state == BEAT) && req;
  assign w_rd_idx = r_base_idx + DEPTH_LOG'(r_beat);

  imem_array #(
    .DEPTH_LOG (DEPTH_LOG),
    .WORD_W    (WORD_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (nrst),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rdata),
    .i_we    (prog_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data)
  );

  // Refill sequencer: capture, latency, beats, gaps, wait for request release
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_base_idx   <= '0;
      r_beat       <= '0;
      r_lat_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_busy       <= 1'b0;
      r_word_ready <= 1'b0;
    end else begin
      r_word_ready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req) begin
            r_base_idx <= w_cap_idx;
            r_beat     <= '0;
            r_lat_cnt  <= LAT_LOAD;
            r_busy     <= 1'b1;
            r_state    <= LAT;
          end
        end
        LAT: begin
          if (!req) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_lat_cnt == '0) begin
            r_state <= BEAT;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        BEAT: begin
          if (!req) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_word_ready <= 1'b1;
            if (r_beat == LAST_BEAT) begin
              r_state <= HOLD;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
              if (BEAT_GAP != 0) begin
                r_gap_cnt <= GAP_LOAD;
                r_state   <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (!req) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_gap_cnt == '0) begin
            r_state <= BEAT;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        HOLD: begin
          // Leaving only on a low request keeps one miss from being served twice
          if (!req) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_word   = w_rdata;
  assign word_ready = r_word_ready;
  assign busy       = r_busy;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: default, gapped and small-depth builds.
module tb_imem_responder;

  logic        clk;
  logic        nrst;
  logic        prog_we_m, prog_we_s;
  logic [11:0] prog_addr;
  logic [31:0] prog_data;

  logic        req_m, req_g, req_s;
  logic [31:0] addr_m, addr_g, addr_s;
  logic [31:0] mw_m, mw_g, mw_s;
  logic        wr_m, wr_g, wr_s;
  logic        busy_m, busy_g, busy_s;

  int n_chk = 0;
  int n_err = 0;

  int          pc[$];
  logic [31:0] pv[$];
  int          b2b;

  imem_responder u_main (
    .clk(clk), .nrst(nrst), .req(req_m), .ram_address(addr_m),
    .mem_word(mw_m), .word_ready(wr_m), .busy(busy_m),
    .prog_we(prog_we_m), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  imem_responder #(.LINE_WORDS(2), .BEAT_GAP(2)) u_gap (
    .clk(clk), .nrst(nrst), .req(req_g), .ram_address(addr_g),
    .mem_word(mw_g), .word_ready(wr_g), .busy(busy_g),
    .prog_we(prog_we_m), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  imem_responder #(.DEPTH_LOG(4)) u_small (
    .clk(clk), .nrst(nrst), .req(req_s), .ram_address(addr_s),
    .mem_word(mw_s), .word_ready(wr_s), .busy(busy_s),
    .prog_we(prog_we_s), .prog_addr(prog_addr[3:0]), .prog_data(prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Sample after edges 0..ncyc-1 following request capture; c is the edge number
  task automatic collect(input int which, input int ncyc, input int drop_at, input int we_at);
    logic        wr, prev;
    logic [31:0] wd;
    pc.delete();
    pv.delete();
    b2b  = 0;
    prev = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      case (which)
        0:       begin wr = wr_m; wd = mw_m; end
        1:       begin wr = wr_g; wd = mw_g; end
        default: begin wr = wr_s; wd = mw_s; end
      endcase
      if (wr) begin
        pc.push_back(c);
        pv.push_back(wd);
        if (prev) b2b++;
      end
      prev = wr;
      if (c == drop_at) begin
        req_m = 1'b0; req_g = 1'b0; req_s = 1'b0;
      end
      prog_we_s = (c == we_at);
      if (c == we_at) begin
        prog_addr = 12'd1;
        prog_data = 32'hDEAD_BEEF;
      end
    end
    prog_we_s = 1'b0;
  endtask

  task automatic expect_pulses(input string tag, input int first_c, input int step,
                               input logic [31:0] first_v, input int n);
    check($sformatf("%s_count", tag), 32'(pc.size()), 32'(n));
    for (int i = 0; i < n && i < pc.size(); i++) begin
      check($sformatf("%s_cyc%0d", tag, i), 32'(pc[i]), 32'(first_c + i * step));
      check($sformatf("%s_val%0d", tag, i), pv[i], first_v + 32'(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    req_m = 1'b0; req_g = 1'b0; req_s = 1'b0;
    addr_m = '0; addr_g = '0; addr_s = '0;
    prog_we_m = 1'b0; prog_we_s = 1'b0; prog_addr = '0; prog_data = '0;

    #1;
    check("rst_wr_m",   32'(wr_m),   32'd0);
    check("rst_busy_m", 32'(busy_m), 32'd0);
    check("rst_mw_m",   mw_m,        32'd0);
    check("rst_wr_g",   32'(wr_g),   32'd0);
    check("rst_busy_s", 32'(busy_s), 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we_m = 1'b1; prog_we_s = 1'b1;
      prog_addr = 12'(i);
      prog_data = 32'h1000_0000 + 32'(i);
    end
    @(negedge clk);
    prog_we_m = 1'b0; prog_we_s = 1'b0;

    // Scenario 1/4: base 0x10, four beats at edges 4..7, then 10 cycles held in HOLD
    addr_m = 32'h0000_0014; req_m = 1'b1;
    collect(0, 18, -1, -1);
    expect_pulses("s1", 4, 1, 32'h1000_0004, 4);
    check("s1_busy_hold", 32'(busy_m), 32'd1);
    req_m = 1'b0;
    check("s1_busy_at_drop", 32'(busy_m), 32'd1);
    @(negedge clk);
    check("s1_busy_after_drop", 32'(busy_m), 32'd0);

    // Scenario 4/5: new burst after low->high, async reset in the middle of BEAT
    req_m = 1'b1;
    collect(0, 6, -1, -1);
    expect_pulses("s4", 4, 1, 32'h1000_0004, 2);
    #2 nrst = 1'b0;
    #1;
    check("s5_wr_async",   32'(wr_m),   32'd0);
    check("s5_busy_async", 32'(busy_m), 32'd0);
    check("s5_mw_async",   mw_m,        32'd0);
    req_m = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    req_m = 1'b1;
    collect(0, 8, -1, -1);
    expect_pulses("s5_fresh", 4, 1, 32'h1000_0004, 4);
    req_m = 1'b0;
    @(negedge clk);

    // Scenario 3: request dropped one cycle after the first beat
    addr_m = 32'h0000_0000; req_m = 1'b1;
    collect(0, 10, 5, -1);
    expect_pulses("s3_drop", 4, 1, 32'h1000_0000, 2);
    check("s3_busy_idle", 32'(busy_m), 32'd0);
    addr_m = 32'h0000_0020; req_m = 1'b1;
    collect(0, 8, -1, -1);
    expect_pulses("s3_next", 4, 1, 32'h1000_0008, 4);
    req_m = 1'b0;
    @(negedge clk);

    // Scenario 2: two-word line with two idle cycles between beats
    addr_g = 32'h0000_0000; req_g = 1'b1;
    collect(1, 12, -1, -1);
    expect_pulses("s2", 4, 3, 32'h1000_0000, 2);
    check("s2_no_b2b", 32'(b2b), 32'd0);
    req_g = 1'b0;
    @(negedge clk);

    // Scenario 6: 0x40 aliases to word 0 in a 16-word array; write collides with read of word 1
    addr_s = 32'h0000_0040; req_s = 1'b1;
    collect(2, 8, -1, 4);
    expect_pulses("s6_alias", 4, 1, 32'h1000_0000, 4);
    req_s = 1'b0;
    @(negedge clk);
    req_s = 1'b1;
    collect(2, 8, -1, -1);
    check("s6_again_count", 32'(pc.size()), 32'd4);
    if (pv.size() >= 2) begin
      check("s6_again_w0", pv[0], 32'h1000_0000);
      check("s6_again_w1", pv[1], 32'hDEAD_BEEF);
    end
    req_s = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
